// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the RV32M divide front-end controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package m_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
    localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

    // op[0] = 1 selects the unsigned variant, op[1] = 1 selects the remainder
    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } div_ctrl_state_e;

    // One-entry cache of the last completed divider result
    typedef struct packed {
        logic            valid;
        logic            sign;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] quot;
        logic [XLEN-1:0] rem;
    } div_cache_t;

endpackage

// File: rtl/div_fixup.sv
// Resolves RISC-V divide corner cases (divide by zero, signed overflow).
// Latency: purely combinational.
// Backpressure: none; no handshake.
// Ports: a, b, sign in; is_special flags a locally-resolved case with its quot/rem.
module div_fixup
    import m_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sign,
    output logic            is_special,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);

    logic div_zero;
    logic overflow;

    assign div_zero = (b == '0);
    assign overflow = sign && (a == INT_MIN) && (b == ALL_ONES);

    always_comb begin
        is_special = div_zero || overflow;
        quot       = '0;
        rem        = '0;
        if (div_zero) begin
            quot = ALL_ONES;
            rem  = a;
        end else if (overflow) begin
            quot = INT_MIN;
            rem  = '0;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Front-end controller for DIV/DIVU/REM/REMU in front of a shared iterative divider.
// Latency: 1 cycle for corner cases and cache hits; otherwise issue + divider time + 1.
// Backpressure: one request in flight; req_ready low until the response is taken or flushed.
// Ports: req_* from execute, resp_* to pipeline, div_in_*/div_out_* to the divider, flush/div_flush abort.
module div_ctrl
    import m_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [XLEN-1:0]   req_a,
    input  logic [XLEN-1:0]   req_b,
    input  logic [TAG_W-1:0]  req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic [TAG_W-1:0]  resp_rd,
    output logic              div_in_valid,
    input  logic              div_in_ready,
    output logic              div_in_sign,
    output logic [XLEN-1:0]   div_in_a,
    output logic [XLEN-1:0]   div_in_b,
    input  logic              div_out_valid,
    output logic              div_out_ready,
    input  logic [XLEN-1:0]   div_quot,
    input  logic [XLEN-1:0]   div_rem,
    output logic              div_flush
);

    div_ctrl_state_e  state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [XLEN-1:0]  a_q, a_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [TAG_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]  resp_data_q, resp_data_d;
    div_cache_t       cache_q, cache_d;

    logic             req_sign;
    logic             fix_special;
    logic [XLEN-1:0]  fix_quot;
    logic [XLEN-1:0]  fix_rem;
    logic             cache_hit;

    // Signed variants have op[0] clear
    assign req_sign = ~req_op[0];

    div_fixup u_fixup (
        .a          (req_a),
        .b          (req_b),
        .sign       (req_sign),
        .is_special (fix_special),
        .quot       (fix_quot),
        .rem        (fix_rem)
    );

    assign cache_hit = cache_q.valid && (cache_q.a == req_a) &&
                       (cache_q.b == req_b) && (cache_q.sign == req_sign);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rd_d        = rd_q;
        resp_data_d = resp_data_q;
        cache_d     = cache_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    rd_d = req_rd;
                    if (fix_special) begin
                        resp_data_d = req_op[1] ? fix_rem : fix_quot;
                        state_d     = RESP;
                    end else if (cache_hit) begin
                        resp_data_d = req_op[1] ? cache_q.rem : cache_q.quot;
                        state_d     = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (div_in_ready) state_d = WAIT;
            end
            WAIT: begin
                // A result arriving in the flush cycle belongs to an aborted divide
                if (div_out_valid && !flush) begin
                    resp_data_d   = op_q[1] ? div_rem : div_quot;
                    cache_d.valid = 1'b1;
                    cache_d.sign  = ~op_q[0];
                    cache_d.a     = a_q;
                    cache_d.b     = b_q;
                    cache_d.quot  = div_quot;
                    cache_d.rem   = div_rem;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            resp_data_q <= '0;
            cache_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            resp_data_q <= resp_data_d;
            cache_q     <= cache_d;
        end
    end

    assign req_ready     = (state_q == IDLE) && !flush;
    assign resp_valid    = (state_q == RESP);
    assign resp_data     = resp_data_q;
    assign resp_rd       = rd_q;
    assign div_in_valid  = (state_q == ISSUE);
    assign div_in_sign   = ~op_q[0];
    assign div_in_a      = a_q;
    assign div_in_b      = b_q;
    assign div_out_ready = (state_q == WAIT);
    assign div_flush     = flush;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with a behavioural 32-cycle divider and reference model.
// Latency: n/a.
// Backpressure: resp_ready held low for a variable number of cycles per response.
module tb_div_ctrl;

    localparam logic [31:0] K_INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] K_ALL_ONES = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        div_in_valid;
    logic        div_in_ready;
    logic        div_in_sign;
    logic [31:0] div_in_a, div_in_b;
    logic        div_out_valid;
    logic        div_out_ready;
    logic [31:0] div_quot, div_rem;
    logic        div_flush;

    int n_chk = 0;
    int n_err = 0;

    // Reference cache: operands of the last divide that completed normally
    bit          m_valid = 0;
    logic [31:0] m_a, m_b;
    bit          m_sign;

    always #5 clock = ~clock;

    div_ctrl dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_rd(resp_rd),
        .div_in_valid(div_in_valid), .div_in_ready(div_in_ready),
        .div_in_sign(div_in_sign), .div_in_a(div_in_a), .div_in_b(div_in_b),
        .div_out_valid(div_out_valid), .div_out_ready(div_out_ready),
        .div_quot(div_quot), .div_rem(div_rem), .div_flush(div_flush)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics in plain arithmetic
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input bit sg,
                           output logic [31:0] q, output logic [31:0] r, output bit special);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        special = 0;
        if (b == 0) begin
            q = K_ALL_ONES; r = a; special = 1;
        end else if (sg && a == K_INT_MIN && b == K_ALL_ONES) begin
            q = K_INT_MIN; r = 0; special = 1;
        end else if (sg) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    // Behavioural divider: 32 cycles after the input handshake, result held until taken
    bit          dv_busy = 0;
    int          dv_cnt  = 0;
    logic [31:0] dv_q, dv_r;
    initial begin
        bit hs, cons, fl, sp;
        div_out_valid = 0;
        div_quot      = 0;
        div_rem       = 0;
        div_in_ready  = 1;
        forever begin
            @(negedge clock);
            hs   = div_in_valid && div_in_ready && !div_flush;
            cons = div_out_valid && div_out_ready && !div_flush;
            fl   = div_flush;
            @(posedge clock);
            #1;
            if (fl || reset) begin
                dv_busy = 0;
                div_out_valid = 0;
            end else if (hs) begin
                dv_busy = 1;
                dv_cnt  = 0;
                ref_div(div_in_a, div_in_b, div_in_sign, dv_q, dv_r, sp);
            end else if (cons) begin
                dv_busy = 0;
                div_out_valid = 0;
            end else if (dv_busy && !div_out_valid) begin
                dv_cnt++;
                if (dv_cnt == 32) begin
                    div_out_valid = 1;
                    div_quot = dv_q;
                    div_rem  = dv_r;
                end
            end
            div_in_ready = !dv_busy;
        end
    end

    task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int hold);
        logic [31:0] eq, er, exp;
        bit sg, sp, hit, issued;
        int lat;
        sg = !op[0];
        ref_div(a, b, sg, eq, er, sp);
        exp = op[1] ? er : eq;
        hit = m_valid && m_a == a && m_b == b && m_sign == sg;

        @(posedge clock); #1;
        req_valid = 1; req_op = op; req_a = a; req_b = b; req_rd = rd; resp_ready = 0;
        @(negedge clock);
        check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clock); #1;
        req_valid = 0;
        lat = 0;
        issued = 0;
        do begin
            @(negedge clock);
            lat++;
            if (div_in_valid) issued = 1;
        end while (!resp_valid && lat < 100);
        check_eq("latency", lat, (sp || hit) ? 32'd1 : 32'd35);
        check_eq("issued", {31'd0, issued}, {31'd0, !(sp || hit)});
        check_eq("resp_data", resp_data, exp);
        check_eq("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check_eq("hold_valid", {31'd0, resp_valid}, 32'd1);
            check_eq("hold_data", resp_data, exp);
            check_eq("hold_rd", {27'd0, resp_rd}, {27'd0, rd});
            check_eq("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clock); #1;
        resp_ready = 1;
        @(posedge clock); #1;
        resp_ready = 0;
        @(negedge clock);
        check_eq("idle_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
        if (!sp && !hit) begin
            m_valid = 1; m_a = a; m_b = b; m_sign = sg;
        end
    endtask

    // Accept a divider-path request, then flush n cycles after acceptance
    task automatic do_flush_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input int n);
        @(posedge clock); #1;
        req_valid = 1; req_op = op; req_a = a; req_b = b; req_rd = rd;
        @(posedge clock); #1;
        req_valid = 0;
        repeat (n) @(posedge clock);
        #1;
        flush = 1;
        @(negedge clock);
        check_eq("flush_div_flush", {31'd0, div_flush}, 32'd1);
        check_eq("flush_in_wait", {31'd0, div_out_ready}, 32'd1);
        check_eq("flush_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clock); #1;
        flush = 0;
        @(negedge clock);
        check_eq("post_flush_req_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            check_eq("post_flush_resp_valid", {31'd0, resp_valid}, 32'd0);
            check_eq("post_flush_div_in_valid", {31'd0, div_in_valid}, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        reset = 1; flush = 0; req_valid = 0; req_op = 0; req_a = 0; req_b = 0;
        req_rd = 0; resp_ready = 0;
        repeat (3) @(posedge clock);
        #1;
        reset = 0;
        @(negedge clock);
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_div_in_valid", {31'd0, div_in_valid}, 32'd0);
        check_eq("rst_div_out_ready", {31'd0, div_out_ready}, 32'd0);
        check_eq("rst_resp_data", resp_data, 32'd0);
        check_eq("rst_resp_rd", {27'd0, resp_rd}, 32'd0);

        do_req(2'd0, 32'd100, 32'd7, 5'd1, 0);
        do_req(2'd2, 32'd100, 32'd7, 5'd2, 0);
        do_req(2'd1, 32'hFFFF_FFFE, 32'd2, 5'd3, 0);
        do_req(2'd0, 32'hFFFF_FFFE, 32'd2, 5'd4, 0);
        do_req(2'd0, 32'd5, 32'd0, 5'd5, 0);
        do_req(2'd3, 32'd5, 32'd0, 5'd6, 0);
        do_req(2'd0, K_INT_MIN, K_ALL_ONES, 5'd7, 0);
        do_req(2'd2, K_INT_MIN, K_ALL_ONES, 5'd8, 0);

        do_flush_req(2'd0, 32'd1000, 32'd3, 5'd9, 10);
        do_req(2'd2, 32'd1000, 32'd3, 5'd10, 10);

        // Flush coincident with a request: nothing is accepted
        @(posedge clock); #1;
        req_valid = 1; flush = 1; req_op = 2'd0; req_a = 32'd77; req_b = 32'd5; req_rd = 5'd11;
        @(negedge clock);
        check_eq("coinc_req_ready", {31'd0, req_ready}, 32'd0);
        check_eq("coinc_div_flush", {31'd0, div_flush}, 32'd1);
        @(posedge clock); #1;
        req_valid = 0; flush = 0;
        @(negedge clock);
        check_eq("coinc_div_in_valid", {31'd0, div_in_valid}, 32'd0);
        check_eq("coinc_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("coinc_req_ready_after", {31'd0, req_ready}, 32'd1);

        ra = 32'd100; rb = 32'd7;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 5))
                    0: ra = 32'd0;
                    1: ra = 32'd100;
                    2: ra = K_INT_MIN;
                    3: ra = K_ALL_ONES;
                    4: ra = 32'd7;
                    default: ra = $urandom;
                endcase
                case ($urandom_range(0, 5))
                    0: rb = 32'd0;
                    1: rb = 32'd1;
                    2: rb = K_ALL_ONES;
                    3: rb = 32'd7;
                    4: rb = 32'd3;
                    default: rb = $urandom_range(1, 1000);
                endcase
            end
            do_req(2'($urandom_range(0, 3)), ra, rb, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Front-end controller for RV32M divide/remainder instructions. It sits between the execute stage and the shared iterative divider, and accepts DIV/DIVU/REM/REMU requests from the pipeline. RISC-V corner cases (divide by zero, signed overflow) are resolved locally, and a one-entry result cache serves back-to-back DIV/REM pairs on the same operands. All other requests are issued to the divider; the controller waits for its result and returns the selected quotient or remainder with the destination tag.

## Interface
Parameters:
- none; widths fixed at XLEN=32, tag width 5.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush; aborts any in-flight request, drops any pending response
- req_valid  in  1  pipeline request valid
- req_ready  out  1  controller can accept a request
- req_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- req_a, req_b  in  32  dividend, divisor
- req_rd  in  5  destination tag
- resp_valid  out  1  result valid
- resp_ready  in  1  pipeline consumes result
- resp_data  out  32  result
- resp_rd  out  5  tag of result
- div_in_valid  out  1  divider request valid
- div_in_ready  in  1  divider idle/accepting
- div_in_sign  out  1  signed divide
- div_in_a, div_in_b  out  32  operands to divider
- div_out_valid  in  1  divider result valid; held until div_out_ready
- div_out_ready  out  1  controller consumes divider result
- div_quot, div_rem  in  32  divider results
- div_flush  out  1  abort to divider; equals flush combinationally

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready = ~flush. On req_valid & req_ready, the controller latches op, a, b, rd and sign = ~op[0], then classifies the request:
  - b == 0: quot = 0xFFFFFFFF, rem = a → RESP.
  - sign & a == 0x80000000 & b == 0xFFFFFFFF: quot = 0x80000000, rem = 0 → RESP.
  - cache hit (cache_valid, a/b/sign all equal): use the cached quot/rem → RESP.
  - otherwise → ISSUE.
- ISSUE: div_in_valid=1 with the latched operands. On div_in_ready & ~flush → WAIT.
- WAIT: div_out_ready=1. On div_out_valid, the controller captures quot/rem, writes the cache (a, b, sign, quot, rem, valid=1) → RESP.
- RESP: resp_valid=1. resp_data = quot for op[1]=0, rem for op[1]=1. resp_rd = latched rd. On resp_ready → IDLE.
- Special-case results never write the cache.
- Flush in any state → IDLE on the next cycle. The request or response is dropped and the cache is unchanged; an aborted divide never writes the cache.
- Flush coincident with req_valid: no accept, since req_ready=0.
- Flush coincident with resp_ready in RESP: this counts as a drop; the pipeline must ignore it.
- Cache is cleared (valid=0) only by reset.

## Timing
- Reset: state=IDLE, cache_valid=0, resp_valid=0, div_in_valid=0, div_out_ready=0, resp_data=0, resp_rd=0. req_ready=1 when flush=0.
- Special case or cache hit: accept at cycle T, resp_valid at T+1.
- Divider path: accept T; ISSUE at T+1. With the divider idle, its handshake completes at T+1, so WAIT starts at T+2. The divider's 32 iterations occupy T+2..T+33, with div_out_valid at T+34. The captured result gives resp_valid at T+35.
- No request is accepted while busy; throughput is one request per RESP→IDLE cycle.
- resp_valid, resp_data and resp_rd are stable from assertion until resp_ready or flush.
- div_in_valid is held stable with its operands until div_in_ready or flush.
- All outputs except req_ready and div_flush are registered or state-decoded.

## Structure
- Package m_pkg:
  - div_op_e (DIV, DIVU, REM, REMU)
  - div_ctrl_state_e (IDLE, ISSUE, WAIT, RESP)
  - constants INT_MIN = 0x80000000 and ALL_ONES = 0xFFFFFFFF
- Sub-module div_fixup (combinational): inputs a, b, sign; outputs is_special, quot, rem. It is instantiated once on the request path.
- The cache registers live in div_ctrl.

## Test plan
- DIV 100/7 → divider issued with sign=1, resp_data=14. Then REM 100/7 → cache hit, resp_data=2 at T+1, div_in_valid never asserts.
- DIVU 0xFFFFFFFE/2 → 0x7FFFFFFF; then DIV 0xFFFFFFFE/2 (same operands, signed) → cache miss, issued, resp_data=0xFFFFFFFF.
- DIV 5/0 → 0xFFFFFFFF at T+1; REMU 5/0 → 5; no divider activity.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0; both at T+1.
- Flush in WAIT mid-divide of 1000/3 → div_flush=1 that cycle, IDLE next cycle, no resp_valid, cache not written. A subsequent REM 1000/3 must issue to the divider and return 1.
- Hold resp_ready=0 for 10 cycles in RESP → resp_valid/resp_data/resp_rd stable and req_ready=0 throughout; resp_ready=1 → IDLE, req_ready=1 next cycle.
